// File: rtl/rep_string_seq_pkg.sv
// Shared execute-stage definitions for the string-op sequencer:
// sequencer states, operand-size codes and the byte-step table.
package rep_string_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    OPSZ_1B = 2'b00,
    OPSZ_2B = 2'b01,
    OPSZ_4B = 2'b10,
    OPSZ_8B = 2'b11
  } opsize_e;

  localparam int unsigned STEP_W = 4;

  // Byte step per operand size: {1,2,4,8}
  function automatic logic [STEP_W-1:0] step_bytes(input opsize_e sz);
    logic [STEP_W-1:0] s;
    case (sz)
      OPSZ_1B: s = 4'd1;
      OPSZ_2B: s = 4'd2;
      OPSZ_4B: s = 4'd4;
      OPSZ_8B: s = 4'd8;
      default: s = 4'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rep_string_seq_if.sv
// Handshake and data bundle between execute (master) and the
// string-op sequencer (slave).
interface rep_string_seq_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned NUM_PTR = 2
);
  logic                        valid_in;
  logic                        ready_out;
  logic                        is_rep;
  logic [ADDR_W-1:0]           count_in;
  logic [NUM_PTR*ADDR_W-1:0]   ptr_in;
  logic [NUM_PTR-1:0]          ptr_en;
  logic [1:0]                  opsize;
  logic                        df;
  logic                        flush;
  logic                        out_stall;
  logic                        iter_valid;
  logic [NUM_PTR*ADDR_W-1:0]   iter_ptr;
  logic [ADDR_W-1:0]           iter_count;
  logic                        iter_last;
  logic                        done;
  logic [NUM_PTR*ADDR_W-1:0]   final_ptr;
  logic [ADDR_W-1:0]           final_count;

  modport master (
    output valid_in, is_rep, count_in, ptr_in, ptr_en, opsize, df, flush, out_stall,
    input  ready_out, iter_valid, iter_ptr, iter_count, iter_last, done, final_ptr, final_count
  );

  modport slave (
    input  valid_in, is_rep, count_in, ptr_in, ptr_en, opsize, df, flush, out_stall,
    output ready_out, iter_valid, iter_ptr, iter_count, iter_last, done, final_ptr, final_count
  );
endinterface

// File: rtl/rep_string_seq_ptr_stepper.sv
// One pointer channel: adds or subtracts the byte step (modulo 2^ADDR_W),
// or passes the pointer through when the channel is disabled.
module ptr_stepper
  import rep_string_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] ptr,
  input  logic [STEP_W-1:0] step,
  input  logic              df,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr_nxt
);
  logic [ADDR_W-1:0] delta;

  // Direction-selected single adder; two's-complement negate for df=1
  always_comb begin
    delta   = df ? (~ADDR_W'(step) + ADDR_W'(1)) : ADDR_W'(step);
    ptr_nxt = en ? (ptr + delta) : ptr;
  end
endmodule

// File: rtl/rep_string_seq.sv
// REP string-op sequencer: accepts one string op from execute, emits one
// beat per iteration with the current pointers/count, then pulses done
// with the post-op architectural values.
module rep_string_seq
  import rep_string_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned NUM_PTR = 2
) (
  input logic             clk,
  input logic             rst,
  rep_string_seq_if.slave bus
);
  localparam int unsigned PW = NUM_PTR * ADDR_W;

  seq_state_e          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d, ptr_step;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                df_q, df_d;
  logic                rep_q, rep_d;
  logic [NUM_PTR-1:0]  en_q, en_d;
  logic                accept, consume, last_beat;

  for (genvar k = 0; k < NUM_PTR; k++) begin : g_step
    ptr_stepper #(.ADDR_W(ADDR_W)) u_ptr_stepper (
      .ptr     (ptr_q[k*ADDR_W +: ADDR_W]),
      .step    (step_q),
      .df      (df_q),
      .en      (en_q[k]),
      .ptr_nxt (ptr_step[k*ADDR_W +: ADDR_W])
    );
  end

  // Next-state and operand capture/update
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    step_d    = step_q;
    df_d      = df_q;
    rep_d     = rep_q;
    en_d      = en_q;
    accept    = bus.valid_in & (state_q == ST_IDLE) & ~bus.flush;
    consume   = (state_q == ST_ITER) & ~bus.flush & ~bus.out_stall;
    // count_q==1 test keeps an all-ones initial count running to the end
    last_beat = ~rep_q | (count_q == ADDR_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ptr_d   = bus.ptr_in;
          count_d = bus.count_in;
          step_d  = step_bytes(opsize_e'(bus.opsize));
          df_d    = bus.df;
          rep_d   = bus.is_rep;
          en_d    = bus.ptr_en;
          state_d = (bus.is_rep && (bus.count_in == '0)) ? ST_DONE : ST_ITER;
        end
      end
      ST_ITER: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (consume) begin
          ptr_d = ptr_step;
          if (rep_q) count_d = count_q - ADDR_W'(1);
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and operand registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      step_q  <= '0;
      df_q    <= 1'b0;
      rep_q   <= 1'b0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      step_q  <= step_d;
      df_q    <= df_d;
      rep_q   <= rep_d;
      en_q    <= en_d;
    end
  end

  // Output decode; flush suppresses any beat or done in its cycle
  always_comb begin
    bus.ready_out   = (state_q == ST_IDLE);
    bus.iter_valid  = (state_q == ST_ITER) & ~bus.flush;
    bus.iter_last   = (state_q == ST_ITER) & ~bus.flush & last_beat;
    bus.iter_ptr    = ptr_q;
    bus.iter_count  = count_q;
    bus.done        = (state_q == ST_DONE) & ~bus.flush;
    bus.final_ptr   = ptr_q;
    bus.final_count = count_q;
  end
endmodule

// File: tb/tb_rep_string_seq.sv
// Directed + randomized bench for rep_string_seq with a per-op arithmetic
// reference model (beat k pointer = base +/- k*step).
module tb_rep_string_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  rep_string_seq_if #(.ADDR_W(32), .NUM_PTR(2)) bus ();
  rep_string_seq_if #(.ADDR_W(8),  .NUM_PTR(2)) b8 ();

  rep_string_seq #(.ADDR_W(32), .NUM_PTR(2)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  rep_string_seq #(.ADDR_W(8), .NUM_PTR(2)) dut8 (
    .clk (clk),
    .rst (rst_n),
    .bus (b8.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_ptr(input logic [31:0] base, input bit en,
                                            input int unsigned beats, input logic [1:0] sz,
                                            input bit d);
    logic [31:0] delta;
    delta = 32'(beats) * (32'd1 << sz);
    if (!en) return base;
    return d ? base - delta : base + delta;
  endfunction

  task automatic accept_op(input bit rep, input logic [31:0] cnt, input logic [31:0] p0,
                           input logic [31:0] p1, input logic [1:0] en, input logic [1:0] sz,
                           input bit d, input string tag);
    @(negedge clk);
    bus.valid_in  = 1'b1;
    bus.is_rep    = rep;
    bus.count_in  = cnt;
    bus.ptr_in    = {p1, p0};
    bus.ptr_en    = en;
    bus.opsize    = sz;
    bus.df        = d;
    bus.out_stall = 1'b0;
    #1;
    chk({tag, "/ready"}, 64'(bus.ready_out), 64'd1);
    @(negedge clk);
    // scramble operands so only the captured copy can be used
    bus.valid_in = 1'b0;
    bus.count_in = $urandom;
    bus.ptr_in   = {$urandom, $urandom};
    bus.ptr_en   = 2'($urandom);
    bus.opsize   = 2'($urandom);
    bus.df       = 1'($urandom);
    bus.is_rep   = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input bit rep, input logic [31:0] cnt,
                        input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] en,
                        input logic [1:0] sz, input bit d, input int unsigned stall_pct,
                        input int unsigned stall_beat, input int unsigned stall_len);
    int unsigned nbeats, i, dheld, cycles;
    bit stall;
    nbeats = rep ? int'(cnt) : 1;
    accept_op(rep, cnt, p0, p1, en, sz, d, tag);
    i = 0; dheld = 0; cycles = 0;
    while (i < nbeats && cycles < 400) begin
      stall = 1'b0;
      if (i == stall_beat && dheld < stall_len) begin
        stall = 1'b1;
        dheld++;
      end else if ($urandom_range(99) < stall_pct) begin
        stall = 1'b1;
      end
      bus.out_stall = stall;
      #1;
      chk({tag, "/iter_valid"}, 64'(bus.iter_valid), 64'd1);
      chk({tag, "/iter_ptr"}, 64'(bus.iter_ptr),
          {model_ptr(p1, en[1], i, sz, d), model_ptr(p0, en[0], i, sz, d)});
      chk({tag, "/iter_count"}, 64'(bus.iter_count), 64'(rep ? cnt - 32'(i) : cnt));
      chk({tag, "/iter_last"}, 64'(bus.iter_last), 64'(i == nbeats - 1));
      chk({tag, "/busy"}, 64'(bus.ready_out), 64'd0);
      if (!stall) i++;
      cycles++;
      @(negedge clk);
    end
    chk({tag, "/beats"}, 64'(i), 64'(nbeats));
    bus.out_stall = 1'b0;
    #1;
    chk({tag, "/done"}, 64'(bus.done), 64'd1);
    chk({tag, "/no_beat"}, 64'(bus.iter_valid), 64'd0);
    chk({tag, "/final_ptr"}, 64'(bus.final_ptr),
        {model_ptr(p1, en[1], nbeats, sz, d), model_ptr(p0, en[0], nbeats, sz, d)});
    chk({tag, "/final_count"}, 64'(bus.final_count), 64'(rep ? 32'd0 : cnt));
    @(negedge clk);
    #1;
    chk({tag, "/done_1cyc"}, 64'(bus.done), 64'd0);
    chk({tag, "/idle"}, 64'(bus.ready_out), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned beats8;
    bus.valid_in = 0; bus.is_rep = 0; bus.count_in = '0; bus.ptr_in = '0;
    bus.ptr_en = '0; bus.opsize = '0; bus.df = 0; bus.flush = 0; bus.out_stall = 0;
    b8.valid_in = 0; b8.is_rep = 0; b8.count_in = '0; b8.ptr_in = '0;
    b8.ptr_en = '0; b8.opsize = '0; b8.df = 0; b8.flush = 0; b8.out_stall = 0;

    // reset state
    #12;
    chk("rst/ready", 64'(bus.ready_out), 64'd1);
    chk("rst/iter_valid", 64'(bus.iter_valid), 64'd0);
    chk("rst/done", 64'(bus.done), 64'd0);
    chk("rst/final_ptr", 64'(bus.final_ptr), 64'd0);
    chk("rst/iter_count", 64'(bus.iter_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_op("movsd", 1, 32'd3, 32'h1000, 32'h2000, 2'b11, 2'b10, 0, 0, 99, 0);
    run_op("movsb", 0, 32'd5, 32'h10, 32'h20, 2'b11, 2'b00, 1, 0, 99, 0);
    run_op("rep0", 1, 32'd0, 32'h1234, 32'h5678, 2'b11, 2'b01, 0, 0, 99, 0);
    run_op("stall", 1, 32'd4, 32'h4000, 32'h8000, 2'b11, 2'b11, 1, 0, 1, 3);
    run_op("wrap", 1, 32'd2, 32'hFFFF_FFFC, 32'h0000_0040, 2'b01, 2'b10, 0, 0, 99, 0);

    // flush on third beat
    accept_op(1, 32'd10, 32'h100, 32'h200, 2'b11, 2'b00, 0, "flush");
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("flush/count_beat3", 64'(bus.iter_count), 64'd8);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush/no_beat", 64'(bus.iter_valid), 64'd0);
    chk("flush/ready", 64'(bus.ready_out), 64'd1);
    chk("flush/no_done", 64'(bus.done), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("flush/no_done_later", 64'(bus.done), 64'd0);
    end

    // valid_in together with flush in IDLE is ignored
    @(negedge clk);
    bus.valid_in = 1'b1; bus.flush = 1'b1; bus.is_rep = 1'b1; bus.count_in = 32'd3;
    @(negedge clk);
    bus.valid_in = 1'b0; bus.flush = 1'b0;
    #1;
    chk("vflush/no_beat", 64'(bus.iter_valid), 64'd0);
    chk("vflush/ready", 64'(bus.ready_out), 64'd1);
    chk("vflush/no_done", 64'(bus.done), 64'd0);

    // flush in DONE suppresses the pulse
    accept_op(1, 32'd0, 32'h1, 32'h2, 2'b11, 2'b00, 0, "fdone");
    bus.flush = 1'b1;
    #1;
    chk("fdone/no_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("fdone/no_done_next", 64'(bus.done), 64'd0);
    chk("fdone/ready", 64'(bus.ready_out), 64'd1);

    // randomized ops with random backpressure
    for (int n = 0; n < 24; n++) begin
      run_op("rand", 1'($urandom), 32'($urandom_range(6)), $urandom, $urandom,
             2'($urandom), 2'($urandom), 1'($urandom), 30, 99, 0);
    end

    // all-ones count runs every beat (8-bit instance, 255 beats)
    @(negedge clk);
    b8.valid_in = 1'b1; b8.is_rep = 1'b1; b8.count_in = 8'hFF;
    b8.ptr_in = {8'h5A, 8'h00}; b8.ptr_en = 2'b01; b8.opsize = 2'b00; b8.df = 1'b0;
    @(negedge clk);
    b8.valid_in = 1'b0;
    beats8 = 0;
    for (int c = 0; c < 600; c++) begin
      #1;
      if (!b8.iter_valid) break;
      chk("full/iter_count", 64'(b8.iter_count), 64'(255 - beats8));
      chk("full/iter_last", 64'(b8.iter_last), 64'(beats8 == 254));
      beats8++;
      @(negedge clk);
    end
    chk("full/beats", 64'(beats8), 64'd255);
    chk("full/done", 64'(b8.done), 64'd1);
    chk("full/final_ptr", 64'(b8.final_ptr), 64'h5AFF);
    chk("full/final_count", 64'(b8.final_count), 64'd0);

    // reset mid-operation
    accept_op(1, 32'd6, 32'hABC0, 32'hDEF0, 2'b11, 2'b01, 0, "rstmid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid/ready", 64'(bus.ready_out), 64'd1);
    chk("rstmid/iter_valid", 64'(bus.iter_valid), 64'd0);
    chk("rstmid/iter_last", 64'(bus.iter_last), 64'd0);
    chk("rstmid/iter_ptr", 64'(bus.iter_ptr), 64'd0);
    chk("rstmid/iter_count", 64'(bus.iter_count), 64'd0);
    chk("rstmid/done", 64'(bus.done), 64'd0);
    chk("rstmid/final_ptr", 64'(bus.final_ptr), 64'd0);
    chk("rstmid/final_count", 64'(bus.final_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      chk("rstmid/no_done", 64'(bus.done), 64'd0);
      chk("rstmid/no_beat", 64'(bus.iter_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
